// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, the decoded entry layout and the field-extraction rules.
// Combinational helpers only; no latency or backpressure of their own.
package decode_pkg;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] imm8;
    logic [8:0] off9;
    logic [2:0] cond;
    logic       mem_we;
    logic       reg_we;
    logic       halt;
    logic       bubble;
  } dec_entry_t;

  // Register fields are masked to the low aw bits so narrower register files alias cleanly.
  function automatic dec_entry_t decode_fields(input logic [15:0] instr, input int unsigned aw);
    dec_entry_t d;
    logic [3:0] op;
    logic [3:0] m;
    op = instr[15:12];
    m  = 4'((32'd1 << aw) - 32'd1);
    d  = '0;
    d.opcode = op;
    d.rd     = instr[11:8] & m;
    d.imm8   = instr[7:0];
    d.cond   = instr[11:9];
    d.off9   = (op == OP_B) ? instr[8:0] : 9'd0;
    if (op >= OP_LW && op <= 4'hB) begin
      d.rs = instr[11:8] & m;
      d.rt = instr[7:4] & m;
    end else begin
      d.rs = instr[7:4] & m;
      d.rt = instr[3:0] & m;
    end
    d.mem_we = (op == OP_SW);
    d.halt   = (op == OP_HLT);
    d.reg_we = (d.rd != 4'd0) && (op <= OP_LW || op == 4'hA || op == 4'hB || op == OP_PCS);
    return d;
  endfunction

  // Opcodes whose rt field is a genuine register read.
  function automatic logic uses_rt(input logic [3:0] op);
    return (op <= 4'h7) || (op == OP_SW) || (op == OP_BR);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count and clear; a pushed word is visible at dout right after the push edge.
// Push is dropped when full, pop ignored when empty; when empty dout holds the last head shown.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = (count != '0) ? mem[rd_ptr] : last_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      last_q <= dout;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits fetched instructions into fields, inserts load-use bubbles, latches halt, honours flush.
// Accepted instruction visible on out_* one edge later; in_ready drops on full, hazard, halt or flush, never on out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_AW         = 4,
  parameter int PC_W           = 16,
  parameter int DEPTH          = 2,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [7:0]        out_imm8,
  output logic [8:0]        out_off9,
  output logic [2:0]        out_cond,
  output logic              out_mem_we,
  output logic              out_reg_we,
  output logic              out_halt,
  output logic              out_bubble,
  output logic [PC_W-1:0]   out_pc,
  output logic              halted
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $bits(dec_entry_t);
  localparam int W  = EW + PC_W;

  dec_entry_t      in_dec, push_entry, head;
  logic [W-1:0]    fifo_dout;
  logic [CW-1:0]   count;
  logic            ld_pend;
  logic [3:0]      ld_rd;
  logic            not_full, hazard, accept, bubble_push, push, pop, is_load;

  assign in_dec   = decode_fields(in_instr, REG_AW);
  assign not_full = count < CW'(DEPTH);
  assign hazard   = (LOAD_USE_STALL != 0) && ld_pend && in_valid &&
                    ((in_dec.rs == ld_rd) || (uses_rt(in_dec.opcode) && (in_dec.rt == ld_rd)));
  assign in_ready = rst_n && !flush && !halted && not_full && !hazard;

  assign accept      = in_valid && in_ready;
  assign bubble_push = hazard && not_full && !flush && !halted;
  assign push        = accept || bubble_push;
  assign pop         = out_valid && out_ready;
  assign is_load     = (in_dec.opcode == OP_LW) && in_dec.reg_we;

  always_comb begin
    push_entry = in_dec;
    if (!accept) begin
      push_entry        = '0;
      push_entry.bubble = 1'b1;
    end
  end

  // Any push that is not a writing load retires the pending-load window, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend <= 1'b0;
      ld_rd   <= '0;
      halted  <= 1'b0;
    end else if (flush) begin
      ld_pend <= 1'b0;
      halted  <= 1'b0;
    end else begin
      if (push) ld_pend <= accept && is_load;
      if (accept && is_load) ld_rd <= in_dec.rd;
      if (accept && in_dec.halt) halted <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .push (push),
    .pop  (pop),
    .din  ({push_entry, in_pc}),
    .dout (fifo_dout),
    .count(count)
  );

  assign head       = fifo_dout[W-1 -: EW];
  assign out_pc     = fifo_dout[PC_W-1:0];
  assign out_valid  = (count != '0);
  assign out_opcode = head.opcode;
  assign out_rd     = head.rd[REG_AW-1:0];
  assign out_rs     = head.rs[REG_AW-1:0];
  assign out_rt     = head.rt[REG_AW-1:0];
  assign out_imm8   = head.imm8;
  assign out_off9   = head.off9;
  assign out_cond   = head.cond;
  assign out_mem_we = head.mem_we;
  assign out_reg_we = head.reg_we;
  assign out_halt   = head.halt;
  assign out_bubble = head.bubble;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: hand-computed decode table, directed corner sequences, and randomized
// traffic checked each cycle against a queue-based reference model.
module tb_decode_stage;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [15:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_mem_we, out_reg_we, out_halt, out_bubble, halted;
  logic [3:0]  out_opcode, out_rd, out_rs, out_rt;
  logic [7:0]  out_imm8;
  logic [8:0]  out_off9;
  logic [2:0]  out_cond;
  logic [15:0] out_pc;

  decode_stage #(.REG_AW(4), .PC_W(16), .DEPTH(DEPTH), .LOAD_USE_STALL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm8(out_imm8), .out_off9(out_off9), .out_cond(out_cond), .out_mem_we(out_mem_we),
    .out_reg_we(out_reg_we), .out_halt(out_halt), .out_bubble(out_bubble), .out_pc(out_pc),
    .halted(halted));

  // Second instance with bubble insertion disabled.
  logic        v1_valid, v1_flush, v1_oready;
  logic [15:0] v1_instr, v1_pc;
  logic        o1_ready, o1_valid, o1_mem_we, o1_reg_we, o1_halt, o1_bubble, o1_halted;
  logic [3:0]  o1_opcode, o1_rd, o1_rs, o1_rt;
  logic [7:0]  o1_imm8;
  logic [8:0]  o1_off9;
  logic [2:0]  o1_cond;
  logic [15:0] o1_pc;

  decode_stage #(.REG_AW(4), .PC_W(16), .DEPTH(DEPTH), .LOAD_USE_STALL(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_valid), .in_ready(o1_ready), .in_instr(v1_instr),
    .in_pc(v1_pc), .flush(v1_flush), .out_valid(o1_valid), .out_ready(v1_oready),
    .out_opcode(o1_opcode), .out_rd(o1_rd), .out_rs(o1_rs), .out_rt(o1_rt),
    .out_imm8(o1_imm8), .out_off9(o1_off9), .out_cond(o1_cond), .out_mem_we(o1_mem_we),
    .out_reg_we(o1_reg_we), .out_halt(o1_halt), .out_bubble(o1_bubble), .out_pc(o1_pc),
    .halted(o1_halted));

  typedef struct packed {
    logic [3:0] op, rd, rs, rt;
    logic [7:0] imm;
    logic [8:0] off;
    logic [2:0] cond;
    logic       mem_we, reg_we, halt, bubble;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op, rd, rs, rt;
    logic [7:0]  imm;
    logic [8:0]  off;
    logic [2:0]  cond;
    logic        mem_we, reg_we, halt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  exp_t m_last = '0;
  logic m_ld_pend = 1'b0;
  logic m_halted  = 1'b0;
  logic [3:0] m_ld_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_decode(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    int v, op, hi, mid, lo;
    v = int'(instr); op = v / 4096; hi = (v / 256) % 16; mid = (v / 16) % 16; lo = v % 16;
    e = '0;
    e.op = 4'(op); e.rd = 4'(hi); e.imm = 8'(v % 256); e.cond = 3'(hi / 2);
    e.off = (op == 12) ? 9'(v % 512) : 9'd0;
    if (op >= 8 && op <= 11) begin e.rs = 4'(hi); e.rt = 4'(mid); end
    else begin e.rs = 4'(mid); e.rt = 4'(lo); end
    e.mem_we = (op == 9);
    e.halt   = (op == 15);
    e.reg_we = (hi != 0) && (op <= 8 || op == 10 || op == 11 || op == 14);
    e.pc = pc;
    return e;
  endfunction

  function automatic logic [63:0] dut_head();
    return {8'h0, out_opcode, out_rd, out_rs, out_rt, out_imm8, out_off9, out_cond,
            out_mem_we, out_reg_we, out_halt, out_bubble, out_pc};
  endfunction

  function automatic void model_reset();
    q.delete(); m_ld_pend = 1'b0; m_halted = 1'b0; m_last = '0;
  endfunction

  // Called at a negedge with inputs already driven; checks, then advances the model across one posedge.
  task automatic cycle();
    exp_t dcur, hd, bub_e;
    logic hz, rdy, acc, bub, rt_used;
    #1;
    dcur    = ref_decode(in_instr, in_pc);
    rt_used = (dcur.op <= 7) || (dcur.op == 9) || (dcur.op == 13);
    hz  = m_ld_pend && in_valid && ((dcur.rs == m_ld_rd) || (rt_used && dcur.rt == m_ld_rd));
    rdy = rst_n && !flush && !m_halted && (q.size() < DEPTH) && !hz;
    hd  = (q.size() > 0) ? q[0] : m_last;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("head", dut_head(), {8'h0, hd});
    chk("halted", 64'(halted), 64'(m_halted));
    m_last = hd;
    acc = in_valid && rdy;
    bub = hz && (q.size() < DEPTH) && !m_halted && !flush;
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin
        q.delete(); m_ld_pend = 1'b0; m_halted = 1'b0;
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          q.push_back(dcur);
          m_ld_pend = (dcur.op == 8) && dcur.reg_we;
          if (m_ld_pend) m_ld_rd = dcur.rd;
          if (dcur.halt) m_halted = 1'b1;
        end else if (bub) begin
          bub_e = '0; bub_e.bubble = 1'b1; bub_e.pc = in_pc;
          q.push_back(bub_e);
          m_ld_pend = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                       input logic f, input logic ordy);
    in_valid = v; in_instr = instr; in_pc = pc; flush = f; out_ready = ordy;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{16'h1234, 4'h1, 4'h2, 4'h3, 4'h4, 8'h34, 9'h000, 3'd1, 1'b0, 1'b1, 1'b0};
    vt[1] = '{16'h8310, 4'h8, 4'h3, 4'h3, 4'h1, 8'h10, 9'h000, 3'd1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{16'h9A52, 4'h9, 4'hA, 4'hA, 4'h5, 8'h52, 9'h000, 3'd5, 1'b1, 1'b0, 1'b0};
    vt[3] = '{16'hC5FF, 4'hC, 4'h5, 4'hF, 4'hF, 8'hFF, 9'h1FF, 3'd2, 1'b0, 1'b0, 1'b0};
    vt[4] = '{16'hF000, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 9'h000, 3'd0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{16'hE000, 4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 9'h000, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{16'hB7C3, 4'hB, 4'h7, 4'h7, 4'hC, 8'hC3, 9'h000, 3'd3, 1'b0, 1'b1, 1'b0};
    vt[7] = '{16'hD801, 4'hD, 4'h8, 4'h0, 4'h1, 8'h01, 9'h000, 3'd4, 1'b0, 1'b0, 1'b0};
    vt[8] = '{16'h0F00, 4'h0, 4'hF, 4'h0, 4'h0, 8'h00, 9'h000, 3'd7, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    v1_valid = 1'b0; v1_instr = 16'h0; v1_pc = 16'h0; v1_flush = 1'b0; v1_oready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    #1 chk("release_ready", 64'(in_ready), 64'd1);
    cycle();

    // Decode table: each vector pushed alone into a freshly flushed stage.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); cycle();
      drive(1'b1, vt[i].instr, 16'h0010 + 16'(i * 2), 1'b0, 1'b0); cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d", i),
          {out_valid, out_bubble, out_opcode, out_rd, out_rs, out_rt, out_imm8, out_off9, out_cond,
           out_mem_we, out_reg_we, out_halt, out_pc},
          {1'b1, 1'b0, vt[i].op, vt[i].rd, vt[i].rs, vt[i].rt, vt[i].imm, vt[i].off, vt[i].cond,
           vt[i].mem_we, vt[i].reg_we, vt[i].halt, 16'h0010 + 16'(i * 2)});
    end

    // Load-use: LW r3 then a reader of r3 costs exactly one bubble.
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'h8310, 16'h0020, 1'b0, 1'b1); cycle();
    drive(1'b1, 16'h2435, 16'h0022, 1'b0, 1'b1);
    #1 chk("lu_stall_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("lu_bubble", {out_valid, out_bubble, out_opcode, out_pc}, {1'b1, 1'b1, 4'h0, 16'h0022});
    #1 chk("lu_resume_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    chk("lu_after", {out_valid, out_bubble, out_opcode, out_rs, out_rt}, {1'b1, 1'b0, 4'h2, 4'h3, 4'h5});
    cycle();

    // Full queue: third push refused even while out_ready is high; order preserved.
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); cycle();
    drive(1'b1, 16'h1111, 16'h0030, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h2222, 16'h0032, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h3333, 16'h0034, 1'b0, 1'b0);
    #1 chk("full_ready", 64'(in_ready), 64'd0);
    cycle();
    out_ready = 1'b1;
    #1 chk("full_ready_ordy", 64'(in_ready), 64'd0);
    cycle();
    chk("full_order2", 64'(out_opcode), 64'h2);
    cycle();
    in_valid = 1'b0;
    chk("full_order3", {out_valid, out_opcode, out_pc}, {1'b1, 4'h3, 16'h0034});
    cycle(); cycle();

    // Branch fields then halt latching until flush.
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'hC5FF, 16'h0040, 1'b0, 1'b1); cycle();
    chk("br_fields", {out_off9, out_cond}, {9'h1FF, 3'd2});
    drive(1'b1, 16'hF000, 16'h0042, 1'b0, 1'b1); cycle();
    chk("halt_set", {halted, out_halt}, {1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234, 16'h0044, 1'b0, 1'b1);
      #1 chk("halt_ready", 64'(in_ready), 64'd0);
      cycle();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1); cycle();
    drive(1'b1, 16'h1234, 16'h0046, 1'b0, 1'b1);
    #1 chk("unhalt", {halted, in_ready}, {1'b0, 1'b1});
    cycle();

    // Flush with two entries queued (one a load) and a valid input pending.
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); cycle();
    drive(1'b1, 16'h1111, 16'h0050, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h8310, 16'h0052, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h5555, 16'h0054, 1'b1, 1'b1); cycle();
    chk("flush_empty", {out_valid, halted}, {1'b0, 1'b0});
    drive(1'b1, 16'h2435, 16'h0056, 1'b0, 1'b0);
    #1 chk("flush_ldpend", 64'(in_ready), 64'd1);
    cycle();
    chk("flush_nobubble", {out_valid, out_bubble, out_opcode}, {1'b1, 1'b0, 4'h2});

    // Asynchronous reset mid-stream.
    drive(1'b1, 16'h1111, 16'h0060, 1'b0, 1'b0); cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_head", dut_head(), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h3456, 16'h0070, 1'b0, 1'b0); cycle();
    in_valid = 1'b0;
    chk("arst_recover", {out_valid, out_opcode, out_pc}, {1'b1, 4'h3, 16'h0070});

    // Randomized traffic against the model; small register indices make hazards frequent.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ri;
      ri = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3))};
      drive($urandom_range(0, 3) != 0, ri, 16'($urandom),
            ($urandom_range(0, 19) == 0) || (m_halted && $urandom_range(0, 3) == 0),
            $urandom_range(0, 2) != 0);
      cycle();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // No-stall instance: the dependent instruction goes straight through.
    v1_valid = 1'b1; v1_instr = 16'h8310; v1_pc = 16'h0080; v1_oready = 1'b1;
    #1 chk("ns_ready_lw", 64'(o1_ready), 64'd1);
    @(negedge clk);
    v1_instr = 16'h2435; v1_pc = 16'h0082;
    #1 chk("ns_ready_dep", 64'(o1_ready), 64'd1);
    chk("ns_head_lw", {o1_valid, o1_opcode}, {1'b1, 4'h8});
    @(negedge clk);
    v1_valid = 1'b0;
    #1 chk("ns_head_dep", {o1_valid, o1_bubble, o1_opcode, o1_pc}, {1'b1, 1'b0, 4'h2, 16'h0082});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled decode stage for the 16-bit core. It sits between fetch and execute: it accepts raw instructions over a valid/ready handshake and splits them into register, immediate, offset and condition fields plus write enables. Decoded entries are buffered in a parametrised output queue. The stage adds load-use bubble insertion, halt latching and flush handling.

## Interface
- `REG_AW`, 4: register index width; field extraction uses the low `REG_AW` bits of each 4-bit field.
- `PC_W`, 16: width of the PC carried alongside each instruction.
- `DEPTH`, 2: output queue entries; power of 2, at least 2.
- `LOAD_USE_STALL`, 1: 1 enables bubble insertion; 0 disables it.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 16: raw instruction.
- `in_pc` in `PC_W`: instruction PC.
- `flush` in 1: discard all queued and in-flight state.
- `out_valid` out 1: queue head is valid.
- `out_ready` in 1: execute consumes the head.
- `out_opcode` out 4: instruction bits [15:12].
- `out_rd` out `REG_AW`: destination register index.
- `out_rs` out `REG_AW`: source A register index.
- `out_rt` out `REG_AW`: source B register index.
- `out_imm8` out 8: immediate field.
- `out_off9` out 9: branch offset field.
- `out_cond` out 3: branch condition field.
- `out_mem_we` out 1: memory write enable.
- `out_reg_we` out 1: register write enable.
- `out_halt` out 1: head entry is a halt.
- `out_bubble` out 1: head entry is an inserted bubble.
- `out_pc` out `PC_W`: PC of the head entry.
- `halted` out 1: a halt has been accepted.

## Operation
- Field rules:
  - rd = [11:8]; imm8 = [7:0]; cond = [11:9].
  - off9 = [8:0] when opcode = 0xC, else 0.
  - Opcodes 0x8–0xB: rs = [11:8], rt = [7:4].
  - All other opcodes: rs = [7:4], rt = [3:0].
  - mem_we = (opcode == 0x9); halt = (opcode == 0xF).
  - reg_we = (rd != 0) and (opcode in {0x0–0x8, 0xA, 0xB, 0xE}).
- Accept when in_valid & in_ready. The decoded entry is pushed into the queue.
- in_ready = rst_n & !flush & !halted & (count < DEPTH) & !hazard.
  - in_ready has no combinational dependence on out_ready.
- Hazard tracking:
  - `ld_pend` and `ld_rd` are set when an accepted opcode is 0x8 with reg_we = 1.
  - Any other push clears `ld_pend`, including bubble pushes.
- Hazard condition: LOAD_USE_STALL & ld_pend & in_valid & (rs == ld_rd or rt == ld_rd).
  - rt is compared only for opcodes 0x0–0x7, 0x9 and 0xD.
- On hazard, if count < DEPTH:
  - Push a bubble: all fields 0, reg_we/mem_we 0, bubble 1, pc = in_pc.
  - Clear `ld_pend`. The instruction is accepted on a later cycle.
- Halt: accepting opcode 0xF sets `halted`. in_ready stays 0 until reset or flush.
- Flush:
  - Synchronously empties the queue and clears `ld_pend` and `halted`.
  - Flush has priority over a simultaneous push and pop; neither takes effect.
- Pop when out_valid & out_ready.
  - Push and pop in the same cycle at count < DEPTH leave count unchanged.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, `ld_pend` = 0, `halted` = 0.
  - out_valid = 0, all out_* fields = 0, in_ready = 0.
- First cycle after release: in_ready = 1.
- Latency: an instruction accepted at edge N is on the outputs with out_valid after edge N when the queue was empty.
- Throughput: 1 instruction per cycle with no hazards.
- Full (count = DEPTH): in_ready = 0 even when out_ready = 1 in that cycle.
- Empty: out_valid = 0, and out_* hold the last values.
- Load-use costs exactly one bubble entry.
- Pointers wrap modulo DEPTH.
- halted rises the cycle after the halt handshake.

## Structure
- Shared package `decode_pkg`:
  - Opcode constants (OP_LW, OP_SW, OP_B, OP_BR, OP_PCS, OP_HLT).
  - `dec_entry_t` struct.
  - `decode_fields()` function for the field rules.
- Sub-module `sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Provides count, push/pop and a synchronous clear.
  - Stores packed `dec_entry_t`.

## Test plan
- Reset, then push 0x1234 at pc 0x0010 → next cycle out_opcode=1, rd=2, rs=3, rt=4, reg_we=1, bubble=0.
- Push 0x8310 (LW rd=3) then 0x2435 (reads rt=5 and rs=3) → outputs are the LW, a bubble, then 0x2435; in_ready=0 for one cycle.
  - Repeat with LOAD_USE_STALL=0 → no bubble.
- Hold out_ready=0 while pushing 3 instructions with DEPTH=2 → in_ready drops after 2; raise out_ready → order preserved, no loss.
- Push 0xC5FF then 0xF000 → off9=0x1FF, cond=2; halted=1 and in_ready=0 until flush.
- Assert flush with 2 entries queued and in_valid=1 → next cycle out_valid=0, halted=0, ld_pend=0, input not accepted.
- Drop rst_n mid-stream asynchronously → out_valid=0 immediately; recovery accepts a new instruction on the first cycle after release.
